// File: rtl/simd_fpu_issue_wb.sv
// Issue driver and writeback collector for the 8-lane/4-cycle SIMD FPU: one warp instruction in flight.
// Optional FPU_ISSUE_PERF_EN adds perf_issued / perf_wb_stall counters.
module simd_fpu_issue_wb #(
    parameter int WARP_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WARP_ID_W  = 3,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [OP_W-1:0]                 in_op,
    input  logic [WARP_ID_W-1:0]            in_warp,
    input  logic [REG_ADDR_W-1:0]           in_rd,
    input  logic [WARP_SIZE-1:0]            in_mask,
    input  logic [WARP_SIZE*DATA_WIDTH-1:0] in_a,
    input  logic [WARP_SIZE*DATA_WIDTH-1:0] in_b,
    input  logic [WARP_SIZE*DATA_WIDTH-1:0] in_c,
    output logic                            fpu_start,
    output logic [OP_W-1:0]                 fpu_op,
    output logic [WARP_SIZE*DATA_WIDTH-1:0] fpu_a,
    output logic [WARP_SIZE*DATA_WIDTH-1:0] fpu_b,
    output logic [WARP_SIZE*DATA_WIDTH-1:0] fpu_c,
    output logic [WARP_SIZE-1:0]            fpu_mask,
    input  logic                            fpu_busy,
    input  logic                            fpu_result_valid,
    input  logic [WARP_SIZE*DATA_WIDTH-1:0] fpu_result,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [WARP_ID_W-1:0]            wb_warp,
    output logic [REG_ADDR_W-1:0]           wb_rd,
    output logic [WARP_SIZE-1:0]            wb_mask,
    output logic [WARP_SIZE*DATA_WIDTH-1:0] wb_data,
    output logic                            done_pulse,
    output logic [WARP_ID_W-1:0]            done_warp,
    output logic [REG_ADDR_W-1:0]           done_rd
`ifdef FPU_ISSUE_PERF_EN
    ,
    output logic [31:0]                     perf_issued,
    output logic [31:0]                     perf_wb_stall
`endif
);

    localparam int VW = WARP_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t                  state_q, state_d;
    logic                    in_ready_q;
    logic [OP_W-1:0]         op_q;
    logic [WARP_ID_W-1:0]    warp_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [WARP_SIZE-1:0]    mask_q;
    logic [VW-1:0]           a_q, b_q, c_q, res_q;

    logic accept, start_fire, wb_fire;

    assign accept     = in_valid && in_ready_q;
    // Start must react to fpu_busy in the same cycle, so it is decoded from the state register.
    assign start_fire = (state_q == ISSUE) && !fpu_busy && !fpu_result_valid;
    assign wb_fire    = (state_q == WB) && wb_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (in_mask == '0) ? WB : ISSUE;
            ISSUE:   if (start_fire) state_d = WAIT;
            WAIT:    if (fpu_result_valid) state_d = WB;
            WB:      if (wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            op_q       <= '0;
            warp_q     <= '0;
            rd_q       <= '0;
            mask_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
            if (accept) begin
                op_q   <= in_op;
                warp_q <= in_warp;
                rd_q   <= in_rd;
                mask_q <= in_mask;
                a_q    <= in_a;
                b_q    <= in_b;
                c_q    <= in_c;
                res_q  <= '0;
            end
            // Result pulses outside WAIT are stale and deliberately dropped.
            if ((state_q == WAIT) && fpu_result_valid) begin
                res_q <= fpu_result;
            end
        end
    end

`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_wb_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q   <= '0;
            perf_wb_stall_q <= '0;
        end else begin
            if (start_fire) perf_issued_q <= perf_issued_q + 32'd1;
            if ((state_q == WB) && !wb_ready) perf_wb_stall_q <= perf_wb_stall_q + 32'd1;
        end
    end

    assign perf_issued   = perf_issued_q;
    assign perf_wb_stall = perf_wb_stall_q;
`endif

    assign in_ready   = in_ready_q;
    assign fpu_start  = start_fire;
    assign fpu_op     = op_q;
    assign fpu_a      = a_q;
    assign fpu_b      = b_q;
    assign fpu_c      = c_q;
    assign fpu_mask   = mask_q;
    assign wb_valid   = (state_q == WB);
    assign wb_warp    = warp_q;
    assign wb_rd      = rd_q;
    assign wb_mask    = mask_q;
    assign wb_data    = res_q;
    assign done_pulse = wb_fire;
    assign done_warp  = warp_q;
    assign done_rd    = rd_q;

endmodule
